// File: rtl/u_bam8_dot_accumulator_if.sv
// Product-in / result-out bus of the dot-product accumulator.
// The master side feeds products and drains results; the slave side is the accumulator.
interface u_bam8_dot_accumulator_if #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
);
    logic [LEN_W-1:0]  cfg_len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_sat;
    logic              busy;

    modport master (
        output cfg_len, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_sat, busy
    );

    modport slave (
        input  cfg_len, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_sat, busy
    );
endinterface

// File: rtl/u_bam8_dot_accumulator.sv
// Saturating dot-product accumulator for the approximate 8-bit multiplier outputs.
// Sums cfg_len products (0 means 2^LEN_W) exactly, clamping at all ones, and
// presents each result on a held valid/ready port.
module u_bam8_dot_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    u_bam8_dot_accumulator_if.slave  bus
);
    typedef enum logic {IDLE, ACC} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [LEN_W:0]   cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q, out_sum_d;
    logic             out_sat_q, out_sat_d;

    logic             in_ready;
    logic             accept;
    logic             final_beat;
    logic [LEN_W:0]   len_full;
    logic [ACC_W:0]   sum;

    // Input only stalls while an undrained result is held; no path from in_valid/in_prod.
    assign in_ready = !rst_i && !(out_valid_q && !bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.busy      = (state_q == ACC);

    // Next-state: first beat loads acc/cnt, later beats add with clamp, final beat publishes.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_sat_d   = out_sat_q;
        final_beat  = 1'b0;
        len_full    = (bus.cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, bus.cfg_len};
        sum         = {1'b0, acc_q} + (ACC_W+1)'(bus.in_prod);

        if (accept) begin
            if (state_q == IDLE) begin
                acc_d      = ACC_W'(bus.in_prod);
                sat_d      = 1'b0;
                cnt_d      = len_full - (LEN_W+1)'(1);
                final_beat = (cnt_d == '0);
            end else begin
                // Adding zero to a clamped acc yields no carry, so sat must be sticky.
                if (sum[ACC_W]) begin
                    acc_d = '1;
                    sat_d = 1'b1;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
                cnt_d      = cnt_q - (LEN_W+1)'(1);
                final_beat = (cnt_q == (LEN_W+1)'(1));
            end
            state_d = final_beat ? IDLE : ACC;
        end

        if (out_valid_q && bus.out_ready)
            out_valid_d = 1'b0;
        if (final_beat) begin
            out_valid_d = 1'b1;
            out_sum_d   = acc_d;
            out_sat_d   = sat_d;
        end
    end

    // State register; reset discards any partial vector and pending result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_sat_q   <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_u_bam8_dot_accumulator.sv
// Bench for u_bam8_dot_accumulator: directed scenarios on a 24-bit and a 16-bit
// accumulator, then random traffic against a sum-and-clamp reference model.
module tb_u_bam8_dot_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   ncmp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    u_bam8_dot_accumulator_if #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) b0 ();
    u_bam8_dot_accumulator_if #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) b1 ();

    u_bam8_dot_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) d0 (
        .clk_i(clk), .rst_i(rst), .bus(b0.slave));
    u_bam8_dot_accumulator #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) d1 (
        .clk_i(clk), .rst_i(rst), .bus(b1.slave));

    // Advance from one falling edge to the next (one rising edge in between).
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        b0.in_valid = 0; b0.in_prod = 0; b0.cfg_len = 0; b0.out_ready = 1;
        b1.in_valid = 0; b1.in_prod = 0; b1.cfg_len = 0; b1.out_ready = 1;
    endtask

    task automatic test_reset();
        logic [27:0] obs;
        rst = 1;
        cyc();
        obs = {b0.in_ready, b0.out_valid, b0.out_sum, b0.out_sat, b0.busy};
        ncmp++;
        if (obs !== 28'h0) begin
            nfail++; $display("FAIL reset_hold b0 rdy/vld/sum/sat/busy got %h want 0", obs);
        end
        ncmp++;
        if ({b1.in_ready, b1.out_valid, b1.out_sum, b1.out_sat, b1.busy} !== 20'h0) begin
            nfail++; $display("FAIL reset_hold b1 got %h want 0",
                {b1.in_ready, b1.out_valid, b1.out_sum, b1.out_sat, b1.busy});
        end
        rst = 0;
        cyc();
        obs = {b0.in_ready, b0.out_valid, b0.out_sum, b0.out_sat, b0.busy};
        ncmp++;
        if (obs !== {1'b1, 27'h0}) begin
            nfail++; $display("FAIL reset_after b0 got %h want %h", obs, {1'b1, 27'h0});
        end
    endtask

    task automatic test_basic();
        logic [15:0] beats [3];
        beats[0] = 16'h0200; beats[1] = 16'h0400; beats[2] = 16'h0600;
        b0.cfg_len = 3; b0.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            b0.in_valid = 1; b0.in_prod = beats[i];
            cyc();
            ncmp++;
            if ({b0.busy, b0.out_valid} !== {(i < 2), 1'b0} && i < 2) begin
                nfail++; $display("FAIL basic_busy beat%0d busy/vld got %b%b want 10", i, b0.busy, b0.out_valid);
            end
        end
        b0.in_valid = 0;
        ncmp++;
        if ({b0.out_valid, b0.out_sum, b0.out_sat, b0.busy} !== {1'b1, 24'h000C00, 1'b0, 1'b0}) begin
            nfail++; $display("FAIL basic_result vld/sum/sat/busy got %b %h %b %b want 1 000c00 0 0",
                b0.out_valid, b0.out_sum, b0.out_sat, b0.busy);
        end
        cyc();
        ncmp++;
        if (b0.out_valid !== 1'b0) begin
            nfail++; $display("FAIL basic_one_cycle out_valid got %b want 0", b0.out_valid);
        end
    endtask

    task automatic test_backpressure();
        b0.cfg_len = 1; b0.in_valid = 1; b0.in_prod = 16'h1E00; b0.out_ready = 0;
        cyc();
        b0.in_prod = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            ncmp++;
            if ({b0.in_ready, b0.out_valid, b0.out_sum} !== {1'b0, 1'b1, 24'h001E00}) begin
                nfail++; $display("FAIL bp_hold cyc%0d rdy/vld/sum got %b %b %h want 0 1 001e00",
                    i, b0.in_ready, b0.out_valid, b0.out_sum);
            end
            cyc();
        end
        b0.out_ready = 1;
        #1;
        ncmp++;
        if (b0.in_ready !== 1'b1) begin
            nfail++; $display("FAIL bp_release in_ready got %b want 1", b0.in_ready);
        end
        cyc();
        b0.in_valid = 0;
        ncmp++;
        if ({b0.out_valid, b0.out_sum} !== {1'b1, 24'h001111}) begin
            nfail++; $display("FAIL bp_drain_load vld/sum got %b %h want 1 001111", b0.out_valid, b0.out_sum);
        end
        cyc();
        ncmp++;
        if (b0.out_valid !== 1'b0) begin
            nfail++; $display("FAIL bp_end out_valid got %b want 0", b0.out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] beats [3];
        beats[0] = 16'hFE00; beats[1] = 16'h0400; beats[2] = 16'h0000;
        b1.cfg_len = 3; b1.out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            b1.in_valid = 1; b1.in_prod = beats[i];
            cyc();
        end
        b1.cfg_len = 1; b1.in_prod = 16'h0010;
        ncmp++;
        if ({b1.out_valid, b1.out_sum, b1.out_sat} !== {1'b1, 16'hFFFF, 1'b1}) begin
            nfail++; $display("FAIL sat_result vld/sum/sat got %b %h %b want 1 ffff 1",
                b1.out_valid, b1.out_sum, b1.out_sat);
        end
        cyc();
        b1.in_valid = 0;
        ncmp++;
        if ({b1.out_valid, b1.out_sum, b1.out_sat} !== {1'b1, 16'h0010, 1'b0}) begin
            nfail++; $display("FAIL sat_next vld/sum/sat got %b %h %b want 1 0010 0",
                b1.out_valid, b1.out_sum, b1.out_sat);
        end
        cyc();
    endtask

    task automatic test_len0();
        int early = 0;
        int nres = 0;
        b0.cfg_len = 0; b0.out_ready = 1; b0.in_prod = 16'hFE00;
        for (int i = 0; i < 256; i++) begin
            b0.in_valid = 1;
            if (i == 1) b0.cfg_len = 8'd2;
            cyc();
            if (i < 255 && b0.out_valid) early++;
        end
        b0.in_valid = 0;
        ncmp++;
        if (early !== 0) begin
            nfail++; $display("FAIL len0_early out_valid cycles got %0d want 0", early);
        end
        ncmp++;
        if ({b0.out_valid, b0.out_sum, b0.out_sat, b0.busy} !== {1'b1, 24'hFE0000, 1'b0, 1'b0}) begin
            nfail++; $display("FAIL len0_result vld/sum/sat/busy got %b %h %b %b want 1 fe0000 0 0",
                b0.out_valid, b0.out_sum, b0.out_sat, b0.busy);
        end
        for (int i = 0; i < 4; i++) begin
            if (b0.out_valid) nres++;
            cyc();
        end
        ncmp++;
        if (nres !== 1) begin
            nfail++; $display("FAIL len0_count results got %0d want 1", nres);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] beats [4];
        logic [23:0] got [2];
        int          k = 0;
        beats[0] = 16'h0300; beats[1] = 16'h0100; beats[2] = 16'h0800; beats[3] = 16'h0800;
        b0.cfg_len = 2; b0.out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            b0.in_valid = 1; b0.in_prod = beats[i];
            cyc();
            if (b0.out_valid && k < 2) begin got[k] = b0.out_sum; k++; end
        end
        b0.in_valid = 0;
        ncmp++;
        if (k !== 2 || got[0] !== 24'h000400 || got[1] !== 24'h001000) begin
            nfail++; $display("FAIL b2b results n=%0d got %h %h want 000400 001000", k, got[0], got[1]);
        end
        cyc();
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        b0.cfg_len = 4; b0.in_valid = 1; b0.in_prod = 16'h0500; b0.out_ready = 1;
        cyc();
        b0.in_valid = 0;
        rst = 1;
        cyc();
        rst = 0;
        cyc();
        ncmp++;
        if ({b0.in_ready, b0.out_valid, b0.out_sum, b0.out_sat, b0.busy} !== {1'b1, 27'h0}) begin
            nfail++; $display("FAIL mid_reset_state rdy/vld/sum/sat/busy got %b %b %h %b %b want 1 0 0 0 0",
                b0.in_ready, b0.out_valid, b0.out_sum, b0.out_sat, b0.busy);
        end
        for (int i = 0; i < 5; i++) begin
            if (b0.out_valid) seen++;
            cyc();
        end
        ncmp++;
        if (seen !== 0) begin
            nfail++; $display("FAIL mid_reset_noresult out_valid cycles got %0d want 0", seen);
        end
        b0.cfg_len = 1; b0.in_valid = 1; b0.in_prod = 16'h0005;
        cyc();
        b0.in_valid = 0;
        ncmp++;
        if ({b0.out_valid, b0.out_sum} !== {1'b1, 24'h000005}) begin
            nfail++; $display("FAIL mid_reset_fresh vld/sum got %b %h want 1 000005", b0.out_valid, b0.out_sum);
        end
        cyc();
    endtask

    // Reference: a vector's result is its exact total clamped to the accumulator maximum.
    task automatic test_random();
        bit          pend = 0;
        longint      total = 0;
        int          n = 0, len = 0;
        logic [23:0] e0 = 0;
        logic [15:0] e1 = 0;
        bit          s0 = 0, s1 = 0;
        bit          rdy, acc;
        logic [15:0] prod;
        logic [7:0]  cl;
        bit          iv, ordy;
        for (int c = 0; c < 600; c++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            prod = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            cl   = 8'($urandom_range(1, 5));
            b0.in_valid = iv; b0.in_prod = prod; b0.cfg_len = cl; b0.out_ready = ordy;
            b1.in_valid = iv; b1.in_prod = prod; b1.cfg_len = cl; b1.out_ready = ordy;
            #1;
            rdy = !(pend && !ordy);
            ncmp++;
            if ({b0.in_ready, b0.out_valid, b0.busy, b1.in_ready, b1.out_valid, b1.busy} !==
                {rdy, pend, (n != 0), rdy, pend, (n != 0)}) begin
                nfail++; $display("FAIL rand_ctrl cyc%0d rdy/vld/busy b0 %b%b%b b1 %b%b%b want %b%b%b",
                    c, b0.in_ready, b0.out_valid, b0.busy, b1.in_ready, b1.out_valid, b1.busy,
                    rdy, pend, (n != 0));
            end
            if (pend) begin
                ncmp++;
                if ({b0.out_sum, b0.out_sat, b1.out_sum, b1.out_sat} !== {e0, s0, e1, s1}) begin
                    nfail++; $display("FAIL rand_result cyc%0d b0 %h/%b b1 %h/%b want %h/%b %h/%b",
                        c, b0.out_sum, b0.out_sat, b1.out_sum, b1.out_sat, e0, s0, e1, s1);
                end
            end
            acc = iv && rdy;
            if (pend && ordy) pend = 0;
            if (acc) begin
                if (n == 0) begin len = int'(cl); total = 0; end
                total += longint'(prod);
                n++;
                if (n == len) begin
                    pend = 1;
                    s0 = (total > 64'hFFFFFF);
                    e0 = s0 ? 24'hFFFFFF : 24'(total);
                    s1 = (total > 64'hFFFF);
                    e1 = s1 ? 16'hFFFF : 16'(total);
                    n = 0;
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        cyc();
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_len0();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/u_bam8_dot_accumulator.md
# u_bam8_dot_accumulator

Sequential accumulation stage directly downstream of the 8-bit unsigned approximate broken-array multipliers (csabam8 family). It consumes one 16-bit approximate product per handshake and sums a configurable number of products into one saturating dot-product result. The result is presented on a held valid/ready output port. Its sum is exact for the products it receives: all approximation error comes from the upstream multiplier, and this block adds none.

## Interface
- `PROD_W`, 16, product width; must equal the upstream multiplier output width.
- `ACC_W`, 24, accumulator and result width; must satisfy ACC_W ≥ PROD_W.
- `LEN_W`, 8, width of the vector-length field.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_len`  in  LEN_W  products per vector; 0 encodes 2^LEN_W. Sampled only on the first beat of a vector.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_prod`  in  PROD_W  approximate product, unsigned.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  ACC_W  accumulated sum, unsigned.
- `out_sat`  out  1  the vector's sum saturated.
- `busy`  out  1  a vector is partially accumulated.

## Operation
- **Beat acceptance.** A beat is accepted when `in_valid && in_ready`. The definition is `in_ready = !rst && !(out_valid && !out_ready)`: input stalls only while an undrained result is held.
- **State machine** (IDLE, ACC):
  - IDLE plus an accepted beat:
    - `acc <= zext(in_prod)`, `sat <= 0`.
    - `cnt <= (cfg_len==0 ? 2^LEN_W : cfg_len) - 1`, held in LEN_W+1 bits.
    - If `cnt` becomes 0 (length 1), the beat is final. Otherwise go to ACC.
  - ACC plus an accepted beat: `sum = acc + zext(in_prod)`, computed in ACC_W+1 bits.
    - If `sum[ACC_W]`, then `acc <= all ones` and `sat <= 1`; otherwise `acc <= sum[ACC_W-1:0]`.
    - Once saturated, `acc` stays at all ones.
    - `cnt <= cnt - 1`. When the pre-decrement `cnt == 1`, the beat is final.
  - Final beat:
    - `out_sum <=` the new acc value and `out_sat <=` the new sat value.
    - `out_valid <= 1`; state returns to IDLE.
- **Output.** `out_sum` and `out_sat` stay stable while `out_valid && !out_ready`. On `out_valid && out_ready`, `out_valid` clears unless a new final beat is accepted in the same cycle, in which case the new result loads and `out_valid` stays 1.
- `busy = (state == ACC)`.
- `cfg_len` changes while in ACC are ignored.
- `in_prod` is treated as an arbitrary PROD_W value. The block makes no assumption about which low bits the upstream multiplier forces to zero.

## Timing
- **Reset values:**
  - `out_valid = 0`, `out_sum = 0`, `out_sat = 0`, `busy = 0`.
  - `in_ready = 0` during the reset cycle and 1 in the first cycle after it.
  - State IDLE, acc = 0, cnt = 0.
- **Reset mid-vector:** the partial sum is discarded and any pending result is dropped. No `out_valid` appears for that vector.
- **Latency:** final beat accepted at edge t, so `out_valid = 1` with the result in cycle t+1. Throughput is one beat per cycle with no bubble between vectors, provided `out_ready` is high.
- **Simultaneous drain and load:** a result drain and a new final beat in the same cycle give back-to-back results with no bubble.
- **Backpressure:** a held result and `!out_ready` force `in_ready = 0`. Accumulation freezes, and neither `acc` nor `cnt` changes.
- **Stalled input:** `in_valid = 0` leaves all state unchanged for any number of cycles.
- No combinational path from `in_valid`/`in_prod` to any output. `in_ready` depends combinationally on `out_ready`, `out_valid` and `rst` only.

## Test plan
- **Basic sum.** `cfg_len = 3`; beats 0x0200, 0x0400, 0x0600 on consecutive cycles with `out_ready = 1`.
  - Expect `out_valid` for exactly 1 cycle, one cycle after the third beat.
  - Expect `out_sum = 0x000C00`, `out_sat = 0`.
  - Expect `busy` high only after beats 1 and 2.
- **Backpressure.** `cfg_len = 1`; beat 0x1E00 with `out_ready = 0` for 5 cycles.
  - Expect `out_valid` and `out_sum = 0x001E00` held.
  - Expect `in_ready = 0` during the stall; a beat offered meanwhile is not consumed.
  - On `out_ready = 1`, expect the held result to drain, then the next beat to be accepted.
- **Saturation.** `ACC_W = 16`, `cfg_len = 3`; beats 0xFE00, 0x0400, 0x0000.
  - Expect `out_sum = 0xFFFF` and `out_sat = 1`.
  - A following vector `cfg_len = 1`, beat 0x0010, gives `out_sum = 0x0010` with `out_sat = 0`.
- **Length 0 encoding.** `cfg_len = 0`; 256 beats of 0xFE00.
  - Expect exactly one result: `out_sum = 0xFE0000`, `out_sat = 0`.
  - Expect no `out_valid` before beat 256.
- **Back-to-back vectors and mid-vector reset.**
  - Two length-2 vectors {0x0300, 0x0100} and {0x0800, 0x0800}, streamed continuously: expect results 0x000400 and 0x001000 on consecutive result cycles.
  - Then assert `rst` after 1 beat of a length-4 vector: expect no result for that vector, all outputs 0, and `in_ready = 1` in the cycle after reset.
